mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side responder for the instruction-cache fetch port and the load/store data port.
- Arbitrates between the two requesters and drives the byte-wide synchronous RAM bus.
- Assembles or splits 32-bit words over 1, 2 or 4 byte beats and returns a one-cycle done pulse with data.
- Sits between the caches/LSU and the top-level RAM/IO pins.

Parameters:
ADDR_W, 32, byte-address width (`MemAddrBus`)
DATA_W, 32, word width (`RegBus`)
IO_BASE_HI, 2'b11, value of addr[17:16] that marks the IO region

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
branch_error  in  1  flush: abort an in-flight fetch
if_request_i  in  1  fetch request, single-cycle pulse
if_addr_i  in  32  fetch byte address (word-aligned)
if_data_o  out  32  fetched word
if_done_o  out  1  fetch complete, one-cycle pulse
if_wait_o  out  1  high = controller cannot accept a fetch this cycle
ls_request_i  in  1  load/store request, held until ls_done_o
ls_we_i  in  1  1 = store, 0 = load
ls_len_i  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 3 = 4 bytes
ls_addr_i  in  32  byte address
ls_wdata_i  in  32  store data, little-endian
ls_data_o  out  32  load data, zero-extended
ls_done_o  out  1  load/store complete, one-cycle pulse
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0 except if_wait_o = 1. A reset mid-transaction drops the transaction with no done pulse.
- RAM timing: address presented in cycle t yields mem_din valid in cycle t+1. A write takes effect in the cycle mem_wr = 1.
- States: IDLE, READ, WRITE.
- IDLE arbitration:
  - ls_request_i has priority over if_request_i.
  - A pending fetch is latched in if_pend (address captured) whenever the controller is busy, so no fetch pulse is lost. There is one pending slot; if_wait_o = 1 whenever if_pend is set or state != IDLE.
  - On selecting a request: latch the address, set nbytes = 4 (fetch) or ls_len_i + 1, clear the counter.
  - A load or fetch goes to READ, a store to WRITE.
  - Accept latency is 0: mem_a = base address in the same cycle the state leaves IDLE.
- READ:
  - Each cycle mem_a = base + cnt for cnt < nbytes, mem_wr = 0.
  - The byte arriving for offset k is written to bits [8k+7:8k].
  - After byte nbytes-1 is captured, pulse the done/data of the owning port for one cycle, then return to IDLE.
  - A 4-byte read completes 5 cycles after acceptance.
  - Unused upper bytes are 0.
- WRITE:
  - Each cycle mem_wr = 1, mem_a = base + cnt, mem_dout = wdata byte cnt.
  - ls_done_o pulses in the cycle after the last byte, then IDLE.
  - A 4-byte store completes 4 cycles after acceptance.
- branch_error:
  - Clears if_pend.
  - If a fetch is in READ, the fetch is abandoned: no if_done_o, state returns to IDLE next cycle, and mem_a/mem_wr go idle.
  - Load/store transactions are unaffected.
- Address arithmetic: base + cnt is a 32-bit add and wraps modulo 2^32.
- Outputs hold 0 (mem_wr = 0, done = 0) whenever no beat is active. Data outputs are valid only in the done cycle.
- Simultaneous fetch and load/store in IDLE: the load/store is served first, then the fetch from if_pend.

Optional Feature:
IO_STALL_EN:
- Defined: a store whose addr[17:16] == IO_BASE_HI stalls in WRITE while io_buffer_full = 1. During the stall mem_wr = 0, the counter is held, and there is no done pulse. The write resumes when io_buffer_full drops.
- Undefined: io_buffer_full is ignored and IO stores behave as normal stores.

Test Plan:
- Fetch: if_addr_i = 0x00000100, RAM bytes 13,05,00,00 -> if_done_o pulse 5 cycles later with if_data_o = 0x00000513. if_wait_o = 1 in between.
- Byte load: ls_len_i = 0, addr 0x204 holds 0xAB -> ls_data_o = 0x000000AB, ls_done_o 2 cycles after acceptance.
- Word store: ls_wdata_i = 0xDEADBEEF at 0x1000 -> mem_a 0x1000..0x1003 with mem_dout EF, BE, AD, DE and mem_wr = 1 for 4 cycles. ls_done_o on the next cycle.
- Collision: fetch pulse and load request in the same IDLE cycle -> load done first, then the fetch completes without a re-request.
- Flush: branch_error at cycle 2 of a fetch -> no if_done_o, IDLE next cycle. A new fetch to 0x200 is then served normally.
- IO_STALL_EN: store of 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write beat, then ls_done_o.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side responder for the instruction fetch port and the
// load/store port. Arbitrates the two requesters onto a byte-wide synchronous
// RAM bus and assembles/splits 32-bit words over 1, 2 or 4 byte beats.
// Optional feature macro: IO_STALL_EN (stall IO-region stores while the UART
// buffer is full). With IO_STALL_EN undefined, io_buffer_full is ignored.
module mem_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic [1:0]  IO_BASE_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_error,
    input  logic              if_request_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_done_o,
    output logic              if_wait_o,
    input  logic              ls_request_i,
    input  logic              ls_we_i,
    input  logic [1:0]        ls_len_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic [DATA_W-1:0] ls_data_o,
    output logic              ls_done_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t            state_q, state_d;
    // READ: offset of the byte arriving this cycle. WRITE: offset of the beat
    // being driven this cycle.
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;      // offset of the final byte (nbytes-1)
    logic              owner_q, owner_d;    // 1 = fetch owns the READ
    logic              if_pend_q, if_pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_data_q, ls_data_d;
    logic              if_wait_q, if_wait_d;

    logic              ls_sel;
    logic              fetch_avail;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall_ls;
    logic              stall_base;

    // The LSU keeps its request up through the done cycle, so it must not be
    // re-accepted while ls_done_o is high.
    assign ls_sel      = !rst && ls_request_i && !ls_done_q;
    assign fetch_avail = !rst && (if_request_i || (if_pend_q && !branch_error));
    assign fetch_addr  = if_request_i ? if_addr_i : pend_addr_q;

`ifdef IO_STALL_EN
    assign stall_ls   = (ls_addr_i[17:16] == IO_BASE_HI) && io_buffer_full;
    assign stall_base = (base_q[17:16] == IO_BASE_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io  = io_buffer_full ^ (^IO_BASE_HI);
    assign stall_ls   = 1'b0;
    assign stall_base = 1'b0;
`endif

    // Next-state, bus drive and result assembly for the current beat.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        if_pend_d   = if_pend_q;
        pend_addr_d = pend_addr_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        if_done_d   = 1'b0;
        ls_done_d   = 1'b0;
        if_data_d   = '0;
        ls_data_d   = '0;
        mem_a       = '0;
        mem_wr      = 1'b0;
        mem_dout    = '0;

        // A fresh fetch pulse always lands in the pending slot; a flush only
        // discards an older one.
        if (if_request_i) begin
            if_pend_d   = 1'b1;
            pend_addr_d = if_addr_i;
        end else if (branch_error) begin
            if_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ls_sel) begin
                    base_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    last_d  = ls_len_i;
                    owner_d = 1'b0;
                    rbuf_d  = '0;
                    cnt_d   = 2'd0;
                    if (!ls_we_i) begin
                        mem_a   = ls_addr_i;
                        state_d = READ;
                    end else if (stall_ls) begin
                        state_d = WRITE;
                    end else begin
                        // First store beat goes out in the accept cycle.
                        mem_a    = ls_addr_i;
                        mem_wr   = 1'b1;
                        mem_dout = ls_wdata_i[7:0];
                        if (ls_len_i == 2'd0) begin
                            ls_done_d = 1'b1;
                        end else begin
                            cnt_d   = 2'd1;
                            state_d = WRITE;
                        end
                    end
                end else if (fetch_avail) begin
                    base_d    = fetch_addr;
                    last_d    = 2'd3;
                    owner_d   = 1'b1;
                    rbuf_d    = '0;
                    cnt_d     = 2'd0;
                    mem_a     = fetch_addr;
                    if_pend_d = 1'b0;
                    state_d   = READ;
                end
            end
            READ: begin
                if (owner_q && branch_error) begin
                    state_d = IDLE;
                end else begin
                    rbuf_d = rbuf_q | (DATA_W'(mem_din) << {cnt_q, 3'b000});
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                        if (owner_q) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_d;
                        end else begin
                            ls_done_d = 1'b1;
                            ls_data_d = rbuf_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        mem_a = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
                    end
                end
            end
            WRITE: begin
                if (!stall_base) begin
                    mem_wr   = 1'b1;
                    mem_a    = base_q + ADDR_W'(cnt_q);
                    mem_dout = wdata_q[{cnt_q, 3'b000} +: 8];
                    if (cnt_q == last_q) begin
                        ls_done_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if_wait_d = if_pend_d || (state_d != IDLE);

        if (rst) begin
            mem_a    = '0;
            mem_wr   = 1'b0;
            mem_dout = '0;
        end
    end

    // Control state and registered port outputs; reset drops any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            owner_q   <= 1'b0;
            if_pend_q <= 1'b0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            if_data_q <= '0;
            ls_data_q <= '0;
            if_wait_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            if_pend_q <= if_pend_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            if_data_q <= if_data_d;
            ls_data_q <= ls_data_d;
            if_wait_q <= if_wait_d;
        end
    end

    // Address/data holding registers; only meaningful while a transaction runs.
    always_ff @(posedge clk) begin
        last_q      <= last_d;
        pend_addr_q <= pend_addr_d;
        base_q      <= base_d;
        wdata_q     <= wdata_d;
        rbuf_q      <= rbuf_d;
    end

    assign if_data_o = if_data_q;
    assign if_done_o = if_done_q;
    assign if_wait_o = if_wait_q;
    assign ls_data_o = ls_data_q;
    assign ls_done_o = ls_done_q;

endmodule
